// File: rtl/ex_div_pkg.sv
// Shared widths, state encoding and control constants for the execute-stage divider.
package ex_div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_ANNUL            = 1'b1;

endpackage

// File: rtl/ex_div_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface ex_div_if
  import ex_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/ex_div_step.sv
// One combinational restoring-division step on the {remainder, dividend} working register.
module ex_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] next_dividend_c
);

  logic [WIDTH:0] diff;

  // Trial subtract of the divisor from the shifted partial remainder; restore on borrow.
  always_comb begin
    diff = dividend[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
    if (diff[WIDTH]) begin
      next_dividend_c = {dividend[2*WIDTH-2:0], 1'b0};
    end else begin
      next_dividend_c = {diff[WIDTH-1:0], dividend[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic   clk,
  input  logic   rst,
  ex_div_if.slave div_bus
);

  div_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2*WIDTH-1:0] dividend, dividend_nxt;
  logic [WIDTH-1:0]   divisor, divisor_nxt;
  logic               neg_quot, neg_quot_nxt;
  logic               neg_rem, neg_rem_nxt;
  logic [2*WIDTH-1:0] result_q, result_nxt;
  logic               ready_q, ready_nxt;
  logic [2*WIDTH-1:0] step_dividend_c;
  logic               op1_neg_c, op2_neg_c;
  logic [WIDTH-1:0]   quot_c, rem_c;

  ex_div_step #(.WIDTH(WIDTH)) u_step (
    .dividend        (dividend),
    .divisor         (divisor),
    .next_dividend_c (step_dividend_c)
  );

  assign div_bus.result_o = result_q;
  assign div_bus.ready_o  = ready_q;

  // Operand signs only matter for DIV; DIVU treats both operands as magnitudes.
  assign op1_neg_c = div_bus.signed_div_i & div_bus.opdata1_i[WIDTH-1];
  assign op2_neg_c = div_bus.signed_div_i & div_bus.opdata2_i[WIDTH-1];

  // Sign correction applied at finalize: quotient truncates toward zero, remainder follows dividend.
  assign quot_c = neg_quot ? WIDTH'(-dividend[WIDTH-1:0])       : dividend[WIDTH-1:0];
  assign rem_c  = neg_rem  ? WIDTH'(-dividend[2*WIDTH-1:WIDTH]) : dividend[2*WIDTH-1:WIDTH];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      neg_quot <= neg_quot_nxt;
      neg_rem  <= neg_rem_nxt;
      result_q <= result_nxt;
      ready_q  <= ready_nxt;
    end
  end

  // Next-state, datapath and output decode; annul takes priority over start everywhere.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    neg_quot_nxt = neg_quot;
    neg_rem_nxt  = neg_rem;
    result_nxt   = result_q;
    ready_nxt    = ready_q;

    unique case (state)
      DIV_FREE: begin
        result_nxt = '0;
        ready_nxt  = DIV_RESULT_NOT_READY;
        if (div_bus.start_i == DIV_START && div_bus.annul_i != DIV_ANNUL) begin
          if (div_bus.opdata2_i == '0) begin
            state_nxt = DIV_BYZERO;
          end else begin
            state_nxt    = DIV_ON;
            cnt_nxt      = '0;
            neg_quot_nxt = op1_neg_c ^ op2_neg_c;
            neg_rem_nxt  = op1_neg_c;
            dividend_nxt = {{WIDTH{1'b0}},
                            op1_neg_c ? WIDTH'(-div_bus.opdata1_i) : div_bus.opdata1_i};
            divisor_nxt  = op2_neg_c ? WIDTH'(-div_bus.opdata2_i) : div_bus.opdata2_i;
          end
        end
      end

      DIV_BYZERO: begin
        result_nxt = '0;
        if (div_bus.annul_i == DIV_ANNUL) begin
          state_nxt = DIV_FREE;
          ready_nxt = DIV_RESULT_NOT_READY;
        end else begin
          state_nxt = DIV_END;
          ready_nxt = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (div_bus.annul_i == DIV_ANNUL) begin
          state_nxt  = DIV_FREE;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_NOT_READY;
        end else if (cnt != CNT_W'(WIDTH)) begin
          dividend_nxt = step_dividend_c;
          cnt_nxt      = cnt + CNT_W'(1);
        end else begin
          state_nxt  = DIV_END;
          result_nxt = {rem_c, quot_c};
          ready_nxt  = DIV_RESULT_READY;
        end
      end

      DIV_END: begin
        if (div_bus.annul_i == DIV_ANNUL || div_bus.start_i == DIV_STOP) begin
          state_nxt  = DIV_FREE;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end

      default: begin
        state_nxt = DIV_FREE;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, divide-by-zero, annul, async reset, hold in END.
module tb_ex_div;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  ex_div_if #(.WIDTH(32)) div_bus ();

  ex_div u_dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (div_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a divide and count edges (accept edge included) until ready_o; operands scrambled after accept.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int edges);
    div_bus.signed_div_i = sgn;
    div_bus.opdata1_i    = a;
    div_bus.opdata2_i    = b;
    div_bus.annul_i      = 1'b0;
    div_bus.start_i      = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        div_bus.opdata1_i = 32'h1234_5678;
        div_bus.opdata2_i = 32'h0000_0003;
      end
    end while (!div_bus.ready_o && edges < 100);
  endtask

  // Drop start for one edge so the divider returns to FREE.
  task automatic drop_start();
    div_bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    div_bus.signed_div_i = 1'b0;
    div_bus.opdata1_i    = '0;
    div_bus.opdata2_i    = '0;
    div_bus.start_i      = 1'b0;
    div_bus.annul_i      = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (div_bus.ready_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ready got %b exp 0", div_bus.ready_o);
    end
    n_vec++;
    if (div_bus.result_o !== 64'd0) begin
      n_err++; $display("FAIL reset_result got %h exp 0", div_bus.result_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned_basic();
    int edges;
    run_div(1'b0, 32'd100, 32'd7, edges);
    n_vec++;
    if (edges !== 34) begin
      n_err++; $display("FAIL divu_100_7_latency got %0d exp 34", edges);
    end
    n_vec++;
    if (div_bus.result_o !== {32'd2, 32'd14}) begin
      n_err++; $display("FAIL divu_100_7_result got %h exp %h", div_bus.result_o, {32'd2, 32'd14});
    end
    drop_start();
    n_vec++;
    if (div_bus.ready_o !== 1'b0 || div_bus.result_o !== 64'd0) begin
      n_err++; $display("FAIL divu_release got ready=%b result=%h exp ready=0 result=0",
                        div_bus.ready_o, div_bus.result_o);
    end
  endtask

  task automatic test_signed();
    int edges;
    run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, edges);
    n_vec++;
    if (edges !== 34 || div_bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL div_m7_2 got edges=%0d result=%h exp 34 ffffffff_fffffffd",
                        edges, div_bus.result_o);
    end
    drop_start();
    run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, edges);
    n_vec++;
    if (edges !== 34 || div_bus.result_o !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL div_7_m2 got edges=%0d result=%h exp 34 00000001_fffffffd",
                        edges, div_bus.result_o);
    end
    drop_start();
    run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, edges);
    n_vec++;
    if (edges !== 34 || div_bus.result_o !== {32'hFFFF_FFFF, 32'h0000_0003}) begin
      n_err++; $display("FAIL div_m7_m2 got edges=%0d result=%h exp 34 ffffffff_00000003",
                        edges, div_bus.result_o);
    end
    drop_start();
  endtask

  task automatic test_div_by_zero();
    int edges;
    run_div(1'b1, 32'd5, 32'd0, edges);
    n_vec++;
    if (edges !== 2) begin
      n_err++; $display("FAIL divzero_latency got %0d exp 2", edges);
    end
    n_vec++;
    if (div_bus.result_o !== 64'd0) begin
      n_err++; $display("FAIL divzero_result got %h exp 0", div_bus.result_o);
    end
    drop_start();
    n_vec++;
    if (div_bus.ready_o !== 1'b0) begin
      n_err++; $display("FAIL divzero_release got ready=%b exp 0", div_bus.ready_o);
    end
  endtask

  task automatic test_annul();
    int edges;
    int seen_ready;
    div_bus.signed_div_i = 1'b0;
    div_bus.opdata1_i    = 32'd1000;
    div_bus.opdata2_i    = 32'd3;
    div_bus.annul_i      = 1'b0;
    div_bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    div_bus.annul_i = 1'b1;
    div_bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    div_bus.annul_i = 1'b0;
    seen_ready = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_bus.ready_o) seen_ready++;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (seen_ready !== 0) begin
      n_err++; $display("FAIL annul_no_ready got %0d ready cycles exp 0", seen_ready);
    end
    run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, edges);
    n_vec++;
    if (edges !== 34 || div_bus.result_o !== {32'h0000_000F, 32'h0FFF_FFFF}) begin
      n_err++; $display("FAIL divu_ffffffff_10 got edges=%0d result=%h exp 34 0000000f_0fffffff",
                        edges, div_bus.result_o);
    end
    drop_start();
  endtask

  task automatic test_async_reset();
    int edges;
    int seen_ready;
    run_div(1'b0, 32'd100, 32'd7, edges);
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if (div_bus.ready_o !== 1'b0 || div_bus.result_o !== 64'd0) begin
      n_err++; $display("FAIL reset_in_end got ready=%b result=%h exp 0 0",
                        div_bus.ready_o, div_bus.result_o);
    end
    div_bus.start_i = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    div_bus.opdata1_i = 32'd100;
    div_bus.opdata2_i = 32'd7;
    div_bus.start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0;
    div_bus.start_i = 1'b0;
    #1;
    n_vec++;
    if (div_bus.ready_o !== 1'b0 || div_bus.result_o !== 64'd0) begin
      n_err++; $display("FAIL reset_mid_on got ready=%b result=%h exp 0 0",
                        div_bus.ready_o, div_bus.result_o);
    end
    #2 rst = 1'b1;
    seen_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (div_bus.ready_o) seen_ready++;
    end
    n_vec++;
    if (seen_ready !== 0) begin
      n_err++; $display("FAIL reset_discard got %0d ready cycles exp 0", seen_ready);
    end
    run_div(1'b0, 32'd9, 32'd3, edges);
    n_vec++;
    if (edges !== 34 || div_bus.result_o !== {32'd0, 32'd3}) begin
      n_err++; $display("FAIL divu_9_3 got edges=%0d result=%h exp 34 00000000_00000003",
                        edges, div_bus.result_o);
    end
    drop_start();
  endtask

  task automatic test_overflow_hold();
    int edges;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges);
    n_vec++;
    if (edges !== 34 || div_bus.result_o !== {32'h0000_0000, 32'h8000_0000}) begin
      n_err++; $display("FAIL div_min_m1 got edges=%0d result=%h exp 34 00000000_80000000",
                        edges, div_bus.result_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (div_bus.ready_o !== 1'b1 || div_bus.result_o !== {32'h0000_0000, 32'h8000_0000}) begin
        n_err++; $display("FAIL end_hold_%0d got ready=%b result=%h exp 1 00000000_80000000",
                          i, div_bus.ready_o, div_bus.result_o);
      end
    end
    drop_start();
    n_vec++;
    if (div_bus.ready_o !== 1'b0 || div_bus.result_o !== 64'd0) begin
      n_err++; $display("FAIL end_release got ready=%b result=%h exp 0 0",
                        div_bus.ready_o, div_bus.result_o);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_async_reset();
    test_overflow_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
